// File: rtl/imm_sel_ctrl.sv
// imm_sel_ctrl: RV32I immediate-select decoder feeding a 2-entry in-order skid buffer.
// Optional macro IMM_ILLEGAL_TRAP_EN enables the out_illegal flag and its storage.
module imm_sel_ctrl #(
  parameter int PCW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    in_instr,
  input  logic [PCW-1:0] in_pc,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    out_instr,
  output logic [PCW-1:0] out_pc,
  output logic [2:0]     out_imm_sel,
  output logic           out_illegal
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nxt;
  logic [31:0] tail_instr;
  logic [PCW-1:0] tail_pc;
  logic [2:0] tail_sel, dec_sel;
  logic acc, con, ld_head_in, ld_head_tail, ld_tail;
  assign in_ready  = state != TWO;
  assign out_valid = state != EMPTY;
  assign acc = in_valid && in_ready && !flush;
  assign con = out_valid && out_ready && !flush;
  // head takes the incoming word when empty, or when the old head leaves as it arrives
  assign ld_head_in   = acc && (state == EMPTY || (state == ONE && con));
  assign ld_tail      = acc && state == ONE && !con;
  assign ld_head_tail = con && state == TWO;
  always_comb begin
    dec_sel = 3'b000;
    case (in_instr[6:0])
      7'b0100011:             dec_sel = 3'b001;
      7'b1100011:             dec_sel = 3'b010;
      7'b0110111, 7'b0010111: dec_sel = 3'b011;
      7'b1101111:             dec_sel = 3'b100;
      default:                dec_sel = 3'b000;
    endcase
  end
  always_comb begin
    state_nxt = flush ? EMPTY
              : state == EMPTY ? (acc ? ONE : EMPTY)
              : state == ONE   ? ((acc && !con) ? TWO : (!acc && con) ? EMPTY : ONE)
              : (con ? ONE : TWO);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out_instr   <= '0;
      out_pc      <= '0;
      out_imm_sel <= '0;
      tail_instr  <= '0;
      tail_pc     <= '0;
      tail_sel    <= '0;
    end else begin
      state <= state_nxt;
      if (ld_head_in) begin
        out_instr   <= in_instr;
        out_pc      <= in_pc;
        out_imm_sel <= dec_sel;
      end else if (ld_head_tail) begin
        out_instr   <= tail_instr;
        out_pc      <= tail_pc;
        out_imm_sel <= tail_sel;
      end
      if (ld_tail) begin
        tail_instr <= in_instr;
        tail_pc    <= in_pc;
        tail_sel   <= dec_sel;
      end
    end
  end
`ifdef IMM_ILLEGAL_TRAP_EN
  logic dec_ill, tail_ill;
  assign dec_ill = !(in_instr[6:0] inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011,
                                           7'b0001111, 7'b0110011, 7'b0100011, 7'b1100011,
                                           7'b0110111, 7'b0010111, 7'b1101111});
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_illegal <= 1'b0;
      tail_ill    <= 1'b0;
    end else begin
      if (ld_head_in) out_illegal <= dec_ill;
      else if (ld_head_tail) out_illegal <= tail_ill;
      if (ld_tail) tail_ill <= dec_ill;
    end
  end
`else
  assign out_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_imm_sel_ctrl.sv
// tb_imm_sel_ctrl: directed self-checking bench for imm_sel_ctrl.
module tb_imm_sel_ctrl;
  logic clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic in_ready, out_valid, out_illegal;
  logic [31:0] in_instr = 0, out_instr, in_pc = 0, out_pc;
  logic [2:0] out_imm_sel;
  int checks = 0, passes = 0;
`ifdef IMM_ILLEGAL_TRAP_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  imm_sel_ctrl #(.PCW(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_imm_sel(out_imm_sel), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else passes++;
    checks++; if (out_instr !== 32'h0) $display("FAIL rst_out_instr got %h exp 0", out_instr); else passes++;
    checks++; if (out_pc !== 32'h0) $display("FAIL rst_out_pc got %h exp 0", out_pc); else passes++;
    checks++; if (out_imm_sel !== 3'b000) $display("FAIL rst_sel got %b exp 000", out_imm_sel); else passes++;
    checks++; if (out_illegal !== 1'b0) $display("FAIL rst_illegal got %b exp 0", out_illegal); else passes++;
    step; rst_n = 1; step;
  endtask

  task automatic test_basic;
    out_ready = 1; in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h100;
    step; in_valid = 0;
    checks++; if (out_valid !== 1'b1) $display("FAIL addi_valid got %b exp 1", out_valid); else passes++;
    checks++; if (out_imm_sel !== 3'b000) $display("FAIL addi_sel got %b exp 000", out_imm_sel); else passes++;
    checks++; if (out_instr !== 32'h00500093) $display("FAIL addi_instr got %h exp 00500093", out_instr); else passes++;
    checks++; if (out_pc !== 32'h100) $display("FAIL addi_pc got %h exp 100", out_pc); else passes++;
    step;
    checks++; if (out_valid !== 1'b0) $display("FAIL addi_drain got %b exp 0", out_valid); else passes++;
  endtask

  task automatic test_back_to_back;
    out_ready = 0; in_valid = 1; in_instr = 32'h00112623; in_pc = 32'h200;
    step; in_instr = 32'h00208463; in_pc = 32'h204;
    step; in_instr = 32'h0000006F; in_pc = 32'h208;
    checks++; if (in_ready !== 1'b0) $display("FAIL two_in_ready got %b exp 0", in_ready); else passes++;
    checks++; if (out_imm_sel !== 3'b001) $display("FAIL two_head_sel got %b exp 001", out_imm_sel); else passes++;
    step;
    checks++; if (out_instr !== 32'h00112623 || out_imm_sel !== 3'b001 || out_pc !== 32'h200)
      $display("FAIL two_stable got %h/%b/%h exp 00112623/001/200", out_instr, out_imm_sel, out_pc); else passes++;
    in_valid = 0; out_ready = 1;
    step;
    checks++; if (out_imm_sel !== 3'b010 || out_instr !== 32'h00208463 || out_pc !== 32'h204)
      $display("FAIL two_second got %h/%b/%h exp 00208463/010/204", out_instr, out_imm_sel, out_pc); else passes++;
    checks++; if (out_valid !== 1'b1) $display("FAIL two_second_valid got %b exp 1", out_valid); else passes++;
    step;
    checks++; if (out_valid !== 1'b0) $display("FAIL two_drain got %b exp 0", out_valid); else passes++;
  endtask

  task automatic test_simultaneous;
    out_ready = 0; in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h300;
    step; out_ready = 1; in_instr = 32'h008000EF; in_pc = 32'h304;
    step; in_instr = 32'h12345037; in_pc = 32'h308;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) $display("FAIL sim_one got v%b r%b exp v1 r1", out_valid, in_ready); else passes++;
    checks++; if (out_imm_sel !== 3'b100 || out_instr !== 32'h008000EF || out_pc !== 32'h304)
      $display("FAIL sim_jal got %h/%b/%h exp 008000EF/100/304", out_instr, out_imm_sel, out_pc); else passes++;
    step; in_valid = 0;
    checks++; if (out_imm_sel !== 3'b011 || out_instr !== 32'h12345037)
      $display("FAIL sim_lui got %h/%b exp 12345037/011", out_instr, out_imm_sel); else passes++;
    step;
    checks++; if (out_valid !== 1'b0) $display("FAIL sim_drain got %b exp 0", out_valid); else passes++;
  endtask

  task automatic test_flush;
    out_ready = 0; in_valid = 1; in_instr = 32'h00112623; in_pc = 32'h400;
    step; in_instr = 32'h00208463;
    step; flush = 1; in_instr = 32'h008000EF;
    step; flush = 0; in_valid = 0; out_ready = 1;
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL flush_ready got %b exp 1", in_ready); else passes++;
    step; step;
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_leak got %b exp 0", out_valid); else passes++;
  endtask

  task automatic test_illegal;
    out_ready = 0; in_valid = 1; in_instr = 32'h0000007F; in_pc = 32'h500;
    step; in_valid = 0;
    checks++; if (out_imm_sel !== 3'b000) $display("FAIL ill_sel got %b exp 000", out_imm_sel); else passes++;
    checks++; if (out_illegal !== ILL_EXP) $display("FAIL ill_flag got %b exp %b", out_illegal, ILL_EXP); else passes++;
    out_ready = 1; in_valid = 1; in_instr = 32'h00500093;
    step; in_valid = 0;
    checks++; if (out_illegal !== 1'b0) $display("FAIL ill_clear got %b exp 0", out_illegal); else passes++;
    step;
  endtask

  task automatic test_async_reset;
    out_ready = 0; in_valid = 1; in_instr = 32'h00112623; in_pc = 32'h600;
    step; in_instr = 32'h00208463;
    step; in_valid = 0;
    #3 rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL arst_vr got v%b r%b exp v0 r1", out_valid, in_ready); else passes++;
    checks++; if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_imm_sel !== 3'b000 || out_illegal !== 1'b0)
      $display("FAIL arst_fields got %h/%h/%b/%b exp 0/0/000/0", out_instr, out_pc, out_imm_sel, out_illegal); else passes++;
    #2 rst_n = 1;
    step;
    checks++; if (out_valid !== 1'b0) $display("FAIL arst_resume got %b exp 0", out_valid); else passes++;
    out_ready = 1; in_valid = 1; in_instr = 32'h008000EF; in_pc = 32'h700;
    step; in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_imm_sel !== 3'b100 || out_pc !== 32'h700)
      $display("FAIL arst_accept got v%b %b %h exp v1 100 700", out_valid, out_imm_sel, out_pc); else passes++;
    step;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_simultaneous;
    test_flush;
    test_illegal;
    test_async_reset;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
